// File: rtl/neuron_sequencer_pkg.sv
// Shared types for the neuron layer sequencer: operand format and controller states.
package neuron_sequencer_pkg;
  localparam int FLOAT_W = 32;
  typedef logic [FLOAT_W-1:0] float_24_8;
  typedef enum logic [2:0] {IDLE, RUN, DRAIN, RESULT, FIN} state_t;
endpackage

// File: rtl/neuron_seq_addr_gen.sv
// Tap index and per-neuron base address generation, with first/last tap flags.
module neuron_seq_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_step,
  input  logic              i_next,
  input  logic [ADDR_W-1:0] i_num_taps,
  output logic [ADDR_W-1:0] o_tap_idx,
  output logic [ADDR_W-1:0] o_tap_addr,
  output logic              o_first,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_base;

  // Base advances by an add per neuron; wraps naturally at 2^ADDR_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_base <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_base <= '0;
    end else if (i_next) begin
      r_idx  <= '0;
      r_base <= r_base + i_num_taps;
    end else if (i_step) begin
      r_idx  <= r_idx + ADDR_W'(1);
    end
  end

  assign o_tap_idx  = r_idx;
  assign o_tap_addr = r_base + r_idx;
  assign o_first    = (r_idx == '0);
  assign o_last     = (r_idx == i_num_taps - ADDR_W'(1));
endmodule

// File: rtl/neuron_sequencer.sv
// Streams a vector and per-neuron taps/bias into a shared MAC neuron, one neuron
// at a time, and returns each neuron's result on a valid/ready port.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int IDX_W      = 8,
  parameter int NEURON_LAT = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_cfg_num_taps,
  input  logic [IDX_W-1:0]  i_cfg_num_neurons,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_data_rd,
  output logic [ADDR_W-1:0] o_data_addr,
  input  float_24_8         i_data_rdata,
  output logic              o_tap_rd,
  output logic [ADDR_W-1:0] o_tap_addr,
  input  float_24_8         i_tap_rdata,
  output logic [IDX_W-1:0]  o_bias_addr,
  input  float_24_8         i_bias_rdata,
  output float_24_8         o_n_data,
  output float_24_8         o_n_tap,
  output float_24_8         o_n_bias,
  output logic              o_n_valid,
  output logic              o_n_first,
  output logic              o_n_last,
  input  float_24_8         i_n_out,
  output float_24_8         o_res_data,
  output logic [IDX_W-1:0]  o_res_index,
  output logic              o_res_valid,
  input  logic              i_res_ready
);
  localparam int LAT_W = $clog2(NEURON_LAT + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_num_taps;
  logic [IDX_W-1:0]  r_num_neurons;
  logic [IDX_W-1:0]  r_idx;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_busy, r_done, r_rd;
  logic              r_n_valid, r_n_first, r_n_last;
  float_24_8         r_res_data;
  logic [IDX_W-1:0]  r_res_index;
  logic              r_res_valid;

  logic              w_accept, w_step, w_hs, w_last_neuron, w_next;
  logic [ADDR_W-1:0] w_tap_idx, w_tap_addr;
  logic              w_first, w_last;

  assign w_accept      = (r_state == IDLE) && i_start;
  assign w_step        = (r_state == RUN) && !w_last;
  assign w_hs          = (r_state == RESULT) && r_res_valid && i_res_ready;
  assign w_last_neuron = (r_idx == r_num_neurons - IDX_W'(1));
  assign w_next        = w_hs && !w_last_neuron;

  neuron_seq_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_accept),
    .i_step     (w_step),
    .i_next     (w_next),
    .i_num_taps (r_num_taps),
    .o_tap_idx  (w_tap_idx),
    .o_tap_addr (w_tap_addr),
    .o_first    (w_first),
    .o_last     (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_num_taps    <= '0;
      r_num_neurons <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rd          <= 1'b0;
      r_n_valid     <= 1'b0;
      r_n_first     <= 1'b0;
      r_n_last      <= 1'b0;
      r_res_data    <= '0;
      r_res_index   <= '0;
      r_res_valid   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      // Memory read latency is one cycle, so qualifiers trail the strobe by one.
      r_n_valid <= r_rd;
      r_n_first <= r_rd & w_first;
      r_n_last  <= r_rd & w_last;
      case (r_state)
        IDLE: if (i_start) begin
          r_num_taps    <= i_cfg_num_taps;
          r_num_neurons <= i_cfg_num_neurons;
          r_idx         <= '0;
          r_busy        <= 1'b1;
          if (i_cfg_num_taps == '0 || i_cfg_num_neurons == '0) begin
            r_state <= FIN;
          end else begin
            r_state <= RUN;
            r_rd    <= 1'b1;
          end
        end
        RUN: if (w_last) begin
          r_rd    <= 1'b0;
          r_state <= DRAIN;
        end
        DRAIN: begin
          if (r_n_valid && r_n_last) begin
            r_cnt <= LAT_W'(NEURON_LAT);
          end else if (r_cnt == LAT_W'(1)) begin
            r_cnt       <= '0;
            r_res_data  <= i_n_out;
            r_res_index <= r_idx;
            r_res_valid <= 1'b1;
            r_state     <= RESULT;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        RESULT: if (w_hs) begin
          r_res_valid <= 1'b0;
          if (w_last_neuron) begin
            r_state <= FIN;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_rd    <= 1'b1;
            r_state <= RUN;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_data_rd   = r_rd;
  assign o_tap_rd    = r_rd;
  assign o_data_addr = w_tap_idx;
  assign o_tap_addr  = w_tap_addr;
  assign o_bias_addr = r_idx;
  // Operands are gated so the neuron never sees stale read data.
  assign o_n_data    = r_n_valid ? i_data_rdata : '0;
  assign o_n_tap     = r_n_valid ? i_tap_rdata  : '0;
  assign o_n_bias    = r_n_valid ? i_bias_rdata : '0;
  assign o_n_valid   = r_n_valid;
  assign o_n_first   = r_n_first;
  assign o_n_last    = r_n_last;
  assign o_res_data  = r_res_data;
  assign o_res_index = r_res_index;
  assign o_res_valid = r_res_valid;
endmodule
